// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: each 32-bit load/store becomes two 16-bit SRAM accesses.
// Optional build macro MEM_ACCESS_CHECK_EN adds alignment/range checking with a mem_err pulse.
module mem_stage_sram_ctrl #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_Res,
  input  logic [31:0]        Val_Rm,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_o,
  input  logic [15:0]        SRAM_DQ_i,
  output logic               SRAM_DQ_oe,
  output logic               SRAM_WE_N,
  output logic               mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  localparam int unsigned     CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WAIT_CYCLES - 1);

  state_t               r_state, r_next;
  logic [CW-1:0]        r_cnt;
  logic                 r_store;
  logic [15:0]          r_hi_data;
  logic [SRAM_AW-2:0]   r_word;

  logic                 w_req;
  logic                 w_last;
  logic                 w_fault;
  logic [SRAM_AW-2:0]   w_word;

  assign w_req  = MEM_R_EN | MEM_W_EN;
  assign w_last = (r_cnt == LAST);
  assign w_word = (SRAM_AW-1)'((ALU_Res - 32'(ADDR_BASE)) >> 2);

`ifdef MEM_ACCESS_CHECK_EN
  logic r_mem_err;

  assign w_fault = (ALU_Res[1:0] != 2'b00) || (ALU_Res < 32'(ADDR_BASE)) ||
                   (((ALU_Res - 32'(ADDR_BASE)) >> (SRAM_AW + 1)) != 32'd0);

  always_ff @(posedge clk) begin
    if (rst) r_mem_err <= 1'b0;
    else     r_mem_err <= (r_state == S_IDLE) && w_req && w_fault;
  end

  assign mem_err = r_mem_err;
`else
  assign w_fault = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) r_next = w_fault ? S_DONE : S_LOW;
      S_LOW:   if (w_last) r_next = S_HIGH;
      S_HIGH:  if (w_last) r_next = S_DONE;
      default: r_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    case (r_state)
      S_IDLE:  ready = ~w_req;
      S_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE || (r_state == S_LOW && w_last)) begin
      r_cnt <= '0;
    end else if (r_state == S_LOW || r_state == S_HIGH) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Bus outputs are registered one state ahead so they are stable for every cycle of LOW/HIGH.
  always_ff @(posedge clk) begin
    if (rst) begin
      readData   <= '0;
      SRAM_ADDR  <= '0;
      SRAM_DQ_o  <= '0;
      SRAM_DQ_oe <= 1'b0;
      SRAM_WE_N  <= 1'b1;
      r_store    <= 1'b0;
      r_hi_data  <= '0;
      r_word     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && !w_fault) begin
            r_store    <= MEM_W_EN;
            r_hi_data  <= Val_Rm[31:16];
            r_word     <= w_word;
            SRAM_ADDR  <= {w_word, 1'b0};
            SRAM_DQ_o  <= Val_Rm[15:0];
            SRAM_DQ_oe <= MEM_W_EN;
            SRAM_WE_N  <= ~MEM_W_EN;
          end
        end
        S_LOW: begin
          if (w_last) begin
            SRAM_ADDR <= {r_word, 1'b1};
            if (r_store) SRAM_DQ_o      <= r_hi_data;
            else         readData[15:0] <= SRAM_DQ_i;
          end
        end
        S_HIGH: begin
          if (w_last) begin
            SRAM_WE_N  <= 1'b1;
            SRAM_DQ_oe <= 1'b0;
            if (!r_store) readData[31:16] <= SRAM_DQ_i;
          end
        end
        default: begin
          SRAM_WE_N  <= 1'b1;
          SRAM_DQ_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl with a behavioural 16-bit SRAM and a 32-bit word model.
module tb_mem_stage_sram_ctrl;

  logic        clk, rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_Res, Val_Rm;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_o, SRAM_DQ_i;
  logic        SRAM_DQ_oe, SRAM_WE_N, mem_err;

  logic [15:0] sram  [0:255];
  logic [31:0] model [0:63];
  logic [31:0] sb_q  [$];
  logic [31:0] exp_rd;
  int          n_total, n_bad;

  mem_stage_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(2), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .readData(readData), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_o(SRAM_DQ_o), .SRAM_DQ_i(SRAM_DQ_i),
    .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign SRAM_DQ_i = sram[SRAM_ADDR[7:0]];

  always @(posedge clk) begin
    if (!SRAM_WE_N) sram[SRAM_ADDR[7:0]] <= SRAM_DQ_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_access(input logic r, input logic w, input logic [31:0] addr,
                           input logic [31:0] data, input logic fault);
    int          lat, we_cnt;
    logic [17:0] a_lo, a_hi, a_before;
    logic [31:0] widx;
    @(negedge clk);
    a_before = SRAM_ADDR;
    MEM_R_EN = r; MEM_W_EN = w; ALU_Res = addr; Val_Rm = data;
    widx = (addr - 32'd1024) >> 2;
    if (!fault) begin
      if (w) model[widx[5:0]] = data;
      else   exp_rd = model[widx[5:0]];
    end
    sb_q.push_back(exp_rd);
    lat = 0; we_cnt = 0; a_lo = '0; a_hi = '0;
    while (lat <= 50) begin
      #1;
      if (ready === 1'b1) break;
      if (lat == 1) a_lo = SRAM_ADDR;
      if (lat == 3) a_hi = SRAM_ADDR;
      if (SRAM_WE_N === 1'b0) we_cnt++;
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, fault ? 32'd1 : 32'd5);
    chk("we_low_cycles", we_cnt, (w && !fault) ? 32'd4 : 32'd0);
    if (!fault) begin
      chk("addr_lo", {14'd0, a_lo}, {14'd0, widx[16:0], 1'b0});
      chk("addr_hi", {14'd0, a_hi}, {14'd0, widx[16:0], 1'b1});
    end else begin
      chk("addr_untouched", {14'd0, SRAM_ADDR}, {14'd0, a_before});
    end
    chk("readData", readData, sb_q.pop_front());
    chk("mem_err", {31'd0, mem_err}, {31'd0, fault});
    chk("done_bus_released", {30'd0, SRAM_WE_N, SRAM_DQ_oe}, 32'd2);
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    n_total = 0; n_bad = 0; exp_rd = '0;
    for (int i = 0; i < 256; i++) sram[i] = '0;
    for (int i = 0; i < 64; i++)  model[i] = '0;
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_Res = '0; Val_Rm = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_readData", readData, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("rst_oe", {31'd0, SRAM_DQ_oe}, 32'd0);
    chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);

    do_access(1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b0);
    chk("sram0", {16'd0, sram[0]}, 32'h5678);
    chk("sram1", {16'd0, sram[1]}, 32'h1234);
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    #1 chk("readData_hold", readData, 32'h12345678);

    do_access(1'b0, 1'b1, 32'd1036, 32'hDEADBEEF, 1'b0);
    do_access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);

    do_access(1'b1, 1'b1, 32'd1028, 32'hA5A5A5A5, 1'b0);
    chk("sram2", {16'd0, sram[2]}, 32'hA5A5);
    chk("sram3", {16'd0, sram[3]}, 32'hA5A5);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);

    // Reset during the second HIGH cycle of a load
    @(negedge clk);
    MEM_R_EN = 1'b1; ALU_Res = 32'd1024;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; MEM_R_EN = 1'b0;
    exp_rd = '0;
    #1;
    chk("midrst_readData", readData, exp_rd);
    chk("midrst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("midrst_oe", {31'd0, SRAM_DQ_oe}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);

    do_access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);

`ifdef MEM_ACCESS_CHECK_EN
    do_access(1'b1, 1'b0, 32'd1026, 32'h0, 1'b1);
    @(negedge clk);
    #1 chk("mem_err_pulse_end", {31'd0, mem_err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
